// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan scheduler for a shared 7-segment bus: steps the digit
// select, blanks the bus at the start of each slot, then enables one anode.
module display_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] num_digits,
    output logic [2:0] sel,
    output logic [7:0] an_n,
    output logic       seg_blank,
    output logic       frame_start
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    nd_q, nd_d;
    logic          fs_d;
    logic [7:0]    an_n_q, an_n_d;
    logic          seg_blank_q, seg_blank_d;
    logic          frame_start_q;

    // State, slot counter, digit select and latched digit count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            sel_q   <= 3'd0;
            nd_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            nd_q    <= nd_d;
        end
    end

    // Next-state logic; a dropped enable overrides every state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        nd_d    = nd_q;
        fs_d    = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            sel_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = CNT_ZERO;
                    sel_d   = 3'd0;
                    nd_d    = num_digits;
                    fs_d    = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                    end else begin
                        state_d = BLANK;
                    end
                end
                SHOW: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = BLANK;
                        if (sel_q == nd_q) begin
                            sel_d = 3'd0;
                            nd_d  = num_digits;
                            fs_d  = 1'b1;
                        end else begin
                            sel_d = sel_q + 3'd1;
                        end
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = SHOW;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                    sel_d   = 3'd0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        an_n_d      = 8'hFF;
        seg_blank_d = 1'b1;
        case (state_d)
            SHOW: begin
                an_n_d      = ~(8'h01 << sel_d);
                seg_blank_d = 1'b0;
            end
            IDLE, BLANK: begin
                an_n_d      = 8'hFF;
                seg_blank_d = 1'b1;
            end
            default: begin
                an_n_d      = 8'hFF;
                seg_blank_d = 1'b1;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n_q        <= 8'hFF;
            seg_blank_q   <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            an_n_q        <= an_n_d;
            seg_blank_q   <= seg_blank_d;
            frame_start_q <= fs_d;
        end
    end

    assign sel         = sel_q;
    assign an_n        = an_n_q;
    assign seg_blank   = seg_blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with CLK_DIV=8, BLANK_CYC=2.
module tb_display_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] num_digits;
    logic [2:0] sel;
    logic [7:0] an_n;
    logic       seg_blank;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;

    display_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .num_digits (num_digits),
        .sel        (sel),
        .an_n       (an_n),
        .seg_blank  (seg_blank),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_an"}, an_n, 8'hFF);
        chk({tag, "_blank"}, {7'd0, seg_blank}, 8'd1);
        chk({tag, "_sel"}, {5'd0, sel}, 8'd0);
        chk({tag, "_fs"}, {7'd0, frame_start}, 8'd0);
    endtask

    // One full 8-cycle digit slot: 2 blank cycles then 6 show cycles
    task automatic slot(input logic [2:0] s, input logic fs);
        logic [7:0] an_exp;
        logic       fs_exp;
        for (int k = 0; k < 8; k++) begin
            if (k < 2) an_exp = 8'hFF;
            else       an_exp = ~(8'h01 << s);
            fs_exp = (k == 0) ? fs : 1'b0;
            chk("slot_an", an_n, an_exp);
            chk("slot_blank", {7'd0, seg_blank}, {7'd0, (k < 2)});
            chk("slot_sel", {5'd0, sel}, {5'd0, s});
            chk("slot_fs", {7'd0, frame_start}, {7'd0, fs_exp});
            step();
        end
    endtask

    initial begin
        logic [7:0] oh_ok;
        logic [7:0] bl_ok;
        logic [7:0] an_sel_ok;
        logic [7:0] an_exp;

        rst_n      = 1'b0;
        en         = 1'b0;
        num_digits = 3'd3;
        @(negedge clk);
        chk_idle("reset");
        @(negedge clk);

        // Test 1: scan 0..3 and wrap
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        slot(3'd0, 1'b1);
        slot(3'd1, 1'b0);
        slot(3'd2, 1'b0);
        slot(3'd3, 1'b0);
        slot(3'd0, 1'b1);

        // Test 2: num_digits change mid-frame only applies at next frame
        num_digits = 3'd7;
        slot(3'd1, 1'b0);
        slot(3'd2, 1'b0);
        slot(3'd3, 1'b0);
        slot(3'd0, 1'b1);
        for (int d = 1; d < 8; d++) slot(d[2:0], 1'b0);
        slot(3'd0, 1'b1);
        slot(3'd1, 1'b0);

        // Test 3: enable drop during digit 2 show
        step(); step(); step();
        chk("pre_drop_an", an_n, 8'hFB);
        en = 1'b0;
        step();
        chk_idle("en_drop");
        step();
        chk_idle("en_low");
        en         = 1'b1;
        num_digits = 3'd2;
        step();
        slot(3'd0, 1'b1);
        slot(3'd1, 1'b0);
        slot(3'd2, 1'b0);
        slot(3'd0, 1'b1);

        // Test 4: asynchronous reset between edges during digit 1 show
        step(); step(); step();
        chk("pre_rst_an", an_n, 8'hFD);
        #2 rst_n = 1'b0;
        #1 chk_idle("async_rst");
        @(negedge clk);
        chk_idle("rst_held");
        rst_n = 1'b1;
        step();
        slot(3'd0, 1'b1);
        slot(3'd1, 1'b0);

        // Test 5: single digit
        en = 1'b0;
        step();
        num_digits = 3'd0;
        en         = 1'b1;
        step();
        slot(3'd0, 1'b1);
        slot(3'd0, 1'b1);
        slot(3'd0, 1'b1);

        // Test 6: invariants under random enable / digit-count changes
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 49) == 0) num_digits = 3'($urandom_range(0, 7));
            step();
            an_exp    = ~(8'h01 << sel);
            oh_ok     = {7'd0, ($countones(~an_n) <= 1)};
            bl_ok     = {7'd0, (seg_blank == (an_n == 8'hFF))};
            an_sel_ok = {7'd0, ((an_n == 8'hFF) || (an_n == an_exp))};
            chk("inv_onehot", oh_ok, 8'd1);
            chk("inv_blank", bl_ok, 8'd1);
            chk("inv_an_sel", an_sel_ok, 8'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
